// File: rtl/bolge_puan_sayaci.sv
// -----------------------------------------------------------------------------
// bolge_puan_sayaci
// Scorer sitting downstream of the bit-run game core. Each posedge it samples
// the core's region and coordinates, keeps a saturating dwell counter per
// region and tracks the peak Manhattan distance from (MERKEZ, MERKEZ).
// When the game ends it picks the region with the largest dwell count
// (lowest index on ties) and offers the result with a valid/ack handshake.
//
// Optional feature macro: BOLGE_GECIS_EN
//   defined   -> region transitions are counted (saturating at 255)
//   undefined -> no transition logic; gecis_sayisi is tied to zero
// -----------------------------------------------------------------------------
module bolge_puan_sayaci #(
    parameter int CNT_W   = 7,
    parameter int KOORD_W = 7,
    parameter int MERKEZ  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         bolge,
    input  logic [KOORD_W-1:0] x,
    input  logic [KOORD_W-1:0] y,
    input  logic               bitti_mi,
    input  logic               sonuc_al,
    output logic               sonuc_gecerli,
    output logic [1:0]         kazanan,
    output logic [CNT_W-1:0]   kazanan_puan,
    output logic [KOORD_W:0]   maks_mesafe,
    output logic [7:0]         gecis_sayisi,
    output logic [2:0]         durum
);

    typedef enum logic [2:0] {
        BOS   = 3'd0,
        TAKIP = 3'd1,
        KARAR = 3'd2,
        RAPOR = 3'd3,
        SON   = 3'd4
    } durum_t;

    localparam logic [CNT_W-1:0]   L_SAYAC_MAKS = '1;
    localparam logic [KOORD_W:0]   L_MERKEZ     = (KOORD_W+1)'(MERKEZ);

    durum_t               r_durum;
    durum_t               w_sonraki;
    logic                 w_gecerli;

    logic [CNT_W-1:0]     r_sayac [4];
    logic [KOORD_W:0]     r_maks_mesafe;
    logic [1:0]           r_kazanan;
    logic [CNT_W-1:0]     r_kazanan_puan;

    logic                 w_ornek;
    logic [KOORD_W:0]     w_x;
    logic [KOORD_W:0]     w_y;
    logic [KOORD_W:0]     w_dx;
    logic [KOORD_W:0]     w_dy;
    logic [KOORD_W:0]     w_mesafe;
    logic [1:0]           w_kaz_idx;
    logic [CNT_W-1:0]     w_kaz_puan;

    // A sample is accumulated only while tracking and the game is still running.
    assign w_ornek = (r_durum == TAKIP) && !bitti_mi;

    // Distance uses the raw wrapped coordinates; one extra bit holds the sum.
    assign w_x      = {1'b0, x};
    assign w_y      = {1'b0, y};
    assign w_dx     = (w_x >= L_MERKEZ) ? (w_x - L_MERKEZ) : (L_MERKEZ - w_x);
    assign w_dy     = (w_y >= L_MERKEZ) ? (w_y - L_MERKEZ) : (L_MERKEZ - w_y);
    assign w_mesafe = w_dx + w_dy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of block ordering.
        if (!rst_n) r_durum <= BOS;
        else        r_durum <= w_sonraki;
    end

    // Next-state and handshake output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        w_sonraki = r_durum;
        w_gecerli = 1'b0;
        case (r_durum)
            BOS:     w_sonraki = TAKIP;           // discard cycle, core bolge still X
            TAKIP:   if (bitti_mi) w_sonraki = KARAR;
            KARAR:   w_sonraki = RAPOR;
            RAPOR: begin
                w_gecerli = 1'b1;
                if (sonuc_al) w_sonraki = SON;
            end
            SON:     w_sonraki = SON;             // only reset leaves SON
            default: w_sonraki = BOS;
        endcase
    end

    // Winner search: strict '>' keeps the lowest index on ties.
    always_comb begin
        w_kaz_idx  = 2'd0;
        w_kaz_puan = r_sayac[0];
        for (int i = 1; i < 4; i++) begin
            if (r_sayac[i] > w_kaz_puan) begin
                w_kaz_idx  = 2'(i);
                w_kaz_puan = r_sayac[i];
            end
        end
    end

    // Per-region saturating dwell counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset explicitly because a mid-game
            // reset must discard all accumulated dwell data.
            for (int i = 0; i < 4; i++) r_sayac[i] <= '0;
        end else if (w_ornek && (r_sayac[bolge] != L_SAYAC_MAKS)) begin
            r_sayac[bolge] <= r_sayac[bolge] + 1'b1;
        end
    end

    // Peak distance tracking while the game runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_maks_mesafe <= '0;
        else if (w_ornek && (w_mesafe > r_maks_mesafe)) r_maks_mesafe <= w_mesafe;
    end

    // Result capture in KARAR; held unchanged through RAPOR and SON.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kazanan      <= 2'd0;
            r_kazanan_puan <= '0;
        end else if (r_durum == KARAR) begin
            r_kazanan      <= w_kaz_idx;
            r_kazanan_puan <= w_kaz_puan;
        end
    end

`ifdef BOLGE_GECIS_EN
    logic [1:0] r_onceki_bolge;
    logic       r_ilk_ornek;
    logic [7:0] r_gecis;

    // Transition counter; the first sample only seeds the previous region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_onceki_bolge <= 2'd0;
            r_ilk_ornek    <= 1'b1;
            r_gecis        <= 8'd0;
        end else if (w_ornek) begin
            r_onceki_bolge <= bolge;
            r_ilk_ornek    <= 1'b0;
            if (!r_ilk_ornek && (bolge != r_onceki_bolge) && (r_gecis != 8'hFF))
                r_gecis <= r_gecis + 8'd1;
        end
    end

    assign gecis_sayisi = r_gecis;
`else
    assign gecis_sayisi = 8'd0;
`endif

    assign sonuc_gecerli = w_gecerli;
    assign kazanan       = r_kazanan;
    assign kazanan_puan  = r_kazanan_puan;
    assign maks_mesafe   = r_maks_mesafe;
    assign durum         = r_durum;

endmodule

// File: tb/tb_bolge_puan_sayaci.sv
// -----------------------------------------------------------------------------
// tb_bolge_puan_sayaci
// Directed stimulus drives the scorer on negedges (as the game core would);
// each finished game pushes its hand-computed result into a queue, and a
// monitor pops and compares whenever sonuc_gecerli rises. Inline checks cover
// reset values, latency, hold behaviour and the async reset.
// -----------------------------------------------------------------------------
module tb_bolge_puan_sayaci;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] bolge = 2'd0;
    logic [6:0] x = 7'd64;
    logic [6:0] y = 7'd64;
    logic       bitti_mi = 1'b0;
    logic       sonuc_al = 1'b0;
    logic       sonuc_gecerli;
    logic [1:0] kazanan;
    logic [6:0] kazanan_puan;
    logic [7:0] maks_mesafe;
    logic [7:0] gecis_sayisi;
    logic [2:0] durum;

    typedef struct {
        logic [1:0] kaz;
        logic [6:0] puan;
        logic [7:0] maks;
        logic [7:0] gecis;
    } beklenen_t;

    beklenen_t q_beklenen[$];
    int n_karsilastirma = 0;
    int n_hata = 0;
    logic r_onceki_gecerli = 1'b0;

    bolge_puan_sayaci #(.CNT_W(7), .KOORD_W(7), .MERKEZ(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bolge         (bolge),
        .x             (x),
        .y             (y),
        .bitti_mi      (bitti_mi),
        .sonuc_al      (sonuc_al),
        .sonuc_gecerli (sonuc_gecerli),
        .kazanan       (kazanan),
        .kazanan_puan  (kazanan_puan),
        .maks_mesafe   (maks_mesafe),
        .gecis_sayisi  (gecis_sayisi),
        .durum         (durum)
    );

    always #5 clk = ~clk;

    task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_karsilastirma++;
        if (gercek !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", ad, gercek, beklenen, $time);
        end
    endtask

    // Expected transition count depends on whether the feature is built in.
    function automatic logic [7:0] gx(input int n);
`ifdef BOLGE_GECIS_EN
        return 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    // Scoreboard monitor: compare each result the cycle valid first rises.
    always @(negedge clk) begin
        beklenen_t e;
        if (sonuc_gecerli && !r_onceki_gecerli) begin
            if (q_beklenen.size() == 0) begin
                n_karsilastirma++;
                n_hata++;
                $display("FAIL sb_unexpected: got=valid expected=no result pending (t=%0t)", $time);
            end else begin
                e = q_beklenen.pop_front();
                check("sb_kazanan", kazanan, e.kaz);
                check("sb_puan", kazanan_puan, e.puan);
                check("sb_maks", maks_mesafe, e.maks);
                check("sb_gecis", gecis_sayisi, e.gecis);
            end
        end
        r_onceki_gecerli = sonuc_gecerli;
    end

    // Reset and release on a negedge; the next posedge is the discard cycle.
    task automatic baslat();
        @(negedge clk);
        #1;
        rst_n = 1'b0; bolge = 2'd0; x = 7'd64; y = 7'd64; bitti_mi = 1'b0; sonuc_al = 1'b0;
        #1;
        check("rst_durum", durum, 0);
        check("rst_gecerli", sonuc_gecerli, 0);
        check("rst_puan", kazanan_puan, 0);
        check("rst_maks", maks_mesafe, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic ornek(input logic [1:0] b, input logic [6:0] xx, input logic [6:0] yy);
        @(negedge clk);
        bolge = b; x = xx; y = yy; bitti_mi = 1'b0;
    endtask

    task automatic bitir(input beklenen_t e);
        @(negedge clk);
        bitti_mi = 1'b1;
        q_beklenen.push_back(e);
        @(negedge clk);
        check("lat_karar_durum", durum, 2);
        check("lat_karar_gecerli", sonuc_gecerli, 0);
        @(negedge clk);
        check("lat_rapor_durum", durum, 3);
        check("lat_rapor_gecerli", sonuc_gecerli, 1);
    endtask

    task automatic onayla();
        @(negedge clk);
        sonuc_al = 1'b1;
        @(negedge clk);
        sonuc_al = 1'b0;
        check("ack_gecerli", sonuc_gecerli, 0);
        check("ack_durum", durum, 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1 + 4: steady region 1 at centre, then handshake hold and ack.
        baslat();
        repeat (9) ornek(2'd1, 7'd64, 7'd64);
        bitir('{kaz: 2'd1, puan: 7'd9, maks: 8'd0, gecis: gx(0)});
        repeat (4) begin
            @(negedge clk);
            check("hold_gecerli", sonuc_gecerli, 1);
            check("hold_kazanan", kazanan, 1);
            check("hold_puan", kazanan_puan, 9);
        end
        onayla();
        bitti_mi = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sonuc_al = ~sonuc_al;
        end
        sonuc_al = 1'b0;
        @(negedge clk);
        check("son_durum", durum, 4);
        check("son_gecerli", sonuc_gecerli, 0);
        check("son_puan", kazanan_puan, 9);

        // Test 2: tie between region 2 and region 0 -> lowest index wins.
        baslat();
        repeat (5) ornek(2'd2, 7'd64, 7'd64);
        repeat (5) ornek(2'd0, 7'd64, 7'd64);
        bitir('{kaz: 2'd0, puan: 7'd5, maks: 8'd0, gecis: gx(1)});
        onayla();

        // Test 3: peak distance held after returning to centre.
        baslat();
        ornek(2'd3, 7'd0, 7'd127);
        @(posedge clk);
        #1;
        check("maks_127", maks_mesafe, 127);
        ornek(2'd3, 7'd64, 7'd64);
        ornek(2'd1, 7'd64, 7'd64);
        bitir('{kaz: 2'd3, puan: 7'd2, maks: 8'd127, gecis: gx(1)});
        onayla();

        // Test 5: region sequence 0,0,1,1,3,0.
        baslat();
        ornek(2'd0, 7'd64, 7'd64);
        ornek(2'd0, 7'd64, 7'd64);
        ornek(2'd1, 7'd64, 7'd64);
        ornek(2'd1, 7'd64, 7'd64);
        ornek(2'd3, 7'd64, 7'd64);
        ornek(2'd0, 7'd64, 7'd64);
        bitir('{kaz: 2'd0, puan: 7'd3, maks: 8'd0, gecis: gx(3)});
        onayla();

        // Test 6: async reset between edges mid-game, then a fresh count.
        baslat();
        ornek(2'd2, 7'd0, 7'd0);
        ornek(2'd3, 7'd0, 7'd0);
        ornek(2'd2, 7'd0, 7'd0);
        @(posedge clk);
        #1;
        check("pre_rst_maks", maks_mesafe, 128);
        check("pre_rst_gecis", gecis_sayisi, gx(2));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_durum", durum, 0);
        check("async_maks", maks_mesafe, 0);
        check("async_gecis", gecis_sayisi, 0);
        check("async_gecerli", sonuc_gecerli, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) ornek(2'd2, 7'd64, 7'd64);
        bitir('{kaz: 2'd2, puan: 7'd4, maks: 8'd0, gecis: gx(0)});
        onayla();

        // Test 7: dwell and transition saturation, both regions tie at max.
        baslat();
        for (int i = 0; i < 260; i++) ornek(2'(i % 2), 7'd127, 7'd127);
        bitir('{kaz: 2'd0, puan: 7'd127, maks: 8'd126, gecis: gx(255)});
        onayla();

        // Test 8: game ends immediately -> all-zero result.
        baslat();
        bitir('{kaz: 2'd0, puan: 7'd0, maks: 8'd0, gecis: gx(0)});
        onayla();

        repeat (3) @(negedge clk);
        check("sb_queue_empty", q_beklenen.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_hata);
        $finish;
    end

endmodule
